// File: rtl/reg_file_sb.sv
// Register file with three read ports, one write port, write bypass
// and a per-register pending-write scoreboard for operand interlocks.
//
// Ports:
//   clk, rst_n           clock, async active-low clear
//   pc_value             mirrored into R[PC_REG] every cycle
//   rs/rt/rd/is_store/rp read indices (rd replaces rt when is_store)
//   wr/r_dest/wb_data    write-back port
//   iss_valid/iss_dest   issue of an instruction producing iss_dest
//   bus_y/bus_z/bus_p    read data
//   busy_y/busy_z/busy_p read index has an outstanding write
//   pend_cnt             number of pending registers
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_REG = 30,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pc_value,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] rp,
  input  logic              wr,
  input  logic [ADDR_W-1:0] r_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dest,
  output logic [DATA_W-1:0] bus_y,
  output logic [DATA_W-1:0] bus_z,
  output logic [DATA_W-1:0] bus_p,
  output logic              busy_y,
  output logic              busy_z,
  output logic              busy_p,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(PC_REG);
  localparam logic BYP = (BYPASS != 0);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pend;
  logic [NREGS-1:0]  pend_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic [ADDR_W-1:0] idx_z;
  logic              wr_ok;

  function automatic logic writable(input logic [ADDR_W-1:0] idx);
    return (idx != '0) && (idx != PC_IDX);
  endfunction

  // Forwarding is suppressed while reset is held so buses read zero.
  function automatic logic fwd(input logic [ADDR_W-1:0] idx);
    return BYP && rst_n && wr && (r_dest == idx);
  endfunction

  function automatic logic [DATA_W-1:0] rd_port(
    input logic [ADDR_W-1:0] idx
  );
    logic [DATA_W-1:0] v;
    v = regs[idx];
    if (idx == '0)
      v = '0;
    else if (fwd(idx) && writable(idx))
      v = wb_data;
    return v;
  endfunction

  assign wr_ok = wr && writable(r_dest);
  assign idx_z = is_store ? rd : rt;

  always_comb begin
    bus_y  = rd_port(rs);
    bus_z  = rd_port(idx_z);
    bus_p  = rd_port(rp);
    busy_y = pend[rs] && !fwd(rs);
    busy_z = pend[idx_z] && !fwd(idx_z);
    busy_p = pend[rp] && !fwd(rp);
  end

  // Clear first, then set: a new producer issued in the same cycle
  // as the old one's write-back keeps the register pending.
  always_comb begin
    pend_nxt = pend;
    if (wr)
      pend_nxt[r_dest] = 1'b0;
    if (iss_valid && writable(iss_dest))
      pend_nxt[iss_dest] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++)
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend_nxt[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      regs[PC_IDX] <= pc_value;
      if (wr_ok)
        regs[r_dest] <= wb_data;
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed cases plus random traffic checked
// against a plain array model, on bypass and non-bypass instances.
module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_value;
  logic [4:0]  rs, rt, rd, rp, r_dest, iss_dest;
  logic        is_store, wr, iss_valid;
  logic [31:0] wb_data;

  logic [31:0] y1, z1, p1, y0, z0, p0;
  logic        by1, bz1, bp1, by0, bz0, bp0;
  logic [5:0]  pc1, pc0;

  int checks;
  int failures;

  logic [31:0] mregs [32];
  bit          mpend [32];

  reg_file_sb #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .pc_value(pc_value),
    .rs(rs), .rt(rt), .rd(rd), .is_store(is_store), .rp(rp),
    .wr(wr), .r_dest(r_dest), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_dest(iss_dest),
    .bus_y(y1), .bus_z(z1), .bus_p(p1),
    .busy_y(by1), .busy_z(bz1), .busy_p(bp1), .pend_cnt(pc1)
  );

  reg_file_sb #(.BYPASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .pc_value(pc_value),
    .rs(rs), .rt(rt), .rd(rd), .is_store(is_store), .rp(rp),
    .wr(wr), .r_dest(r_dest), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_dest(iss_dest),
    .bus_y(y0), .bus_z(z0), .bus_p(p0),
    .busy_y(by0), .busy_z(bz0), .busy_p(bp0), .pend_cnt(pc0)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit wrt(input logic [4:0] i);
    return i != 0 && i != 30;
  endfunction

  function automatic logic [31:0] mrd(input logic [4:0] i, input bit byp);
    if (!rst_n || i == 0) return 0;
    if (byp && wr && r_dest == i && wrt(i)) return wb_data;
    return mregs[i];
  endfunction

  function automatic bit mbusy(input logic [4:0] i, input bit byp);
    if (!rst_n) return 0;
    return mpend[i] && !(byp && wr && r_dest == i);
  endfunction

  function automatic int mcnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(mpend[i]);
    return n;
  endfunction

  task automatic mclear();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = 0;
      mpend[i] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) mclear();
    else begin
      mregs[30] = pc_value;
      if (wr && wrt(r_dest)) mregs[r_dest] = wb_data;
      if (wr) mpend[r_dest] = 0;
      if (iss_valid && wrt(iss_dest)) mpend[iss_dest] = 1;
    end
    #1;
  endtask

  task automatic check_all();
    logic [4:0] iz;
    #1;
    iz = is_store ? rd : rt;
    chk("y1", y1, mrd(rs, 1));
    chk("z1", z1, mrd(iz, 1));
    chk("p1", p1, mrd(rp, 1));
    chk("y0", y0, mrd(rs, 0));
    chk("z0", z0, mrd(iz, 0));
    chk("p0", p0, mrd(rp, 0));
    chk("by1", by1, mbusy(rs, 1));
    chk("bz1", bz1, mbusy(iz, 1));
    chk("bp1", bp1, mbusy(rp, 1));
    chk("by0", by0, mbusy(rs, 0));
    chk("bz0", bz0, mbusy(iz, 0));
    chk("bp0", bp0, mbusy(rp, 0));
    chk("cnt1", pc1, 64'(mcnt()));
    chk("cnt0", pc0, 64'(mcnt()));
  endtask

  task automatic idle();
    wr = 0; iss_valid = 0; is_store = 0;
    rs = 0; rt = 0; rd = 0; rp = 0;
    r_dest = 0; iss_dest = 0; wb_data = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    mclear();
    rst_n = 0;
    pc_value = 0;
    idle();
    #12;
    check_all();
    chk("rst_cnt", pc1, 0);
    rst_n = 1;
    tick();

    // Write R5 then clear asynchronously mid-cycle.
    wr = 1; r_dest = 5; wb_data = 32'hDEADBEEF;
    iss_valid = 1; iss_dest = 8;
    check_all();
    tick();
    idle(); rs = 5;
    check_all();
    chk("r5", y1, 32'hDEADBEEF);
    chk("cnt_pre", pc1, 1);
    rst_n = 0;
    mclear();
    #1;
    chk("rst_y", y1, 0);
    chk("rst_c", pc1, 0);
    tick();
    rst_n = 1;
    check_all();
    tick();

    // Hardwired registers.
    wr = 1; r_dest = 0; wb_data = 32'h1234; rs = 0;
    check_all();
    chk("r0_y", y1, 0);
    tick();
    wr = 1; r_dest = 30; wb_data = 32'h55; pc_value = 32'h100;
    tick();
    idle(); rp = 30; pc_value = 32'h104;
    check_all();
    chk("pc_hold", p1, 32'h100);
    tick();
    check_all();
    chk("pc_new", p1, 32'h104);

    // Store mux and bypass.
    idle();
    wr = 1; r_dest = 7; wb_data = 32'h11;
    tick();
    r_dest = 9; wb_data = 32'h22;
    tick();
    idle(); is_store = 1; rd = 9; rt = 7;
    check_all();
    chk("z_st", z1, 32'h22);
    wr = 1; r_dest = 9; wb_data = 32'h33;
    check_all();
    chk("z_byp", z1, 32'h33);
    chk("z_nobyp", z0, 32'h22);
    tick();
    wr = 0;
    check_all();
    chk("z_after", z0, 32'h33);

    // Scoreboard set / clear.
    idle(); iss_valid = 1; iss_dest = 12;
    tick();
    idle(); rs = 12;
    check_all();
    chk("sb_busy", by1, 1);
    chk("sb_cnt", pc1, 1);
    wr = 1; r_dest = 12; wb_data = 32'h77;
    check_all();
    chk("sb_byp", by1, 0);
    chk("sb_nobyp", by0, 1);
    tick();
    wr = 0;
    check_all();
    chk("sb_clr", pc1, 0);

    // Simultaneous set and clear, then issues to 0 and 30.
    iss_valid = 1; iss_dest = 12;
    tick();
    wr = 1; r_dest = 12; wb_data = 32'h99;
    tick();
    idle(); rs = 12;
    check_all();
    chk("ss_busy", by1, 1);
    chk("ss_cnt", pc1, 1);
    chk("ss_data", y1, 32'h99);
    iss_valid = 1; iss_dest = 0;
    tick();
    iss_dest = 30;
    tick();
    iss_valid = 0;
    check_all();
    chk("iss_hw", pc1, 1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      if (!rst_n) mclear();
      pc_value = $urandom;
      wr = $urandom_range(0, 1);
      r_dest = 5'($urandom_range(0, 31));
      wb_data = $urandom;
      iss_valid = ($urandom_range(0, 2) != 0);
      iss_dest = 5'($urandom_range(0, 31));
      is_store = $urandom_range(0, 1);
      rs = $urandom_range(0, 1) ? r_dest : 5'($urandom_range(0, 31));
      rt = $urandom_range(0, 3) == 0 ? r_dest : 5'($urandom_range(0, 31));
      rd = $urandom_range(0, 3) == 0 ? r_dest : 5'($urandom_range(0, 31));
      rp = $urandom_range(0, 3) == 0 ? 5'd30 : 5'($urandom_range(0, 31));
      check_all();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the pipeline's 32x32 register file.
- Three combinational read ports (Rs, Rt/Rd store-mux, Rp) and one write port.
- Adds asynchronous clear, optional write-to-read bypass, and a per-register pending-write scoreboard that tells decode when an operand's producer has not yet written back.
- Sits between decode (read/issue) and write-back (WR/R_dest/WBData).

Parameters:
- DATA_W, 32: register and bus width.
- ADDR_W, 5: register index width; NREGS = 2**ADDR_W.
- PC_REG, 30: index mirrored from pc_value every cycle; writes to it are ignored.
- BYPASS, 1: 1 = same-cycle write data forwarded to the read buses; 0 = no forwarding.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_value  in  DATA_W  PC value mirrored into R[PC_REG].
- rs  in  ADDR_W  read index for bus_y.
- rt  in  ADDR_W  read index for bus_z when is_store=0.
- rd  in  ADDR_W  read index for bus_z when is_store=1.
- is_store  in  1  selects rd instead of rt for bus_z.
- rp  in  ADDR_W  read index for bus_p (predicate register).
- wr  in  1  write-back enable.
- r_dest  in  ADDR_W  write-back index.
- wb_data  in  DATA_W  write-back data.
- iss_valid  in  1  an instruction writing iss_dest issues this cycle.
- iss_dest  in  ADDR_W  destination of the issuing instruction.
- bus_y  out  DATA_W  read data for rs.
- bus_z  out  DATA_W  read data for the rt/rd mux.
- bus_p  out  DATA_W  read data for rp.
- busy_y  out  1  rs has an outstanding write.
- busy_z  out  1  rt/rd mux index has an outstanding write.
- busy_p  out  1  rp has an outstanding write.
- pend_cnt  out  ADDR_W+1  number of registers currently marked pending.

Behaviour:
- Clock and reset: clk is the only clock; rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous):
  - All R[i] are cleared to 0 and all pending bits to 0.
  - Therefore bus_*=0, busy_*=0 and pend_cnt=0 while reset is held.
  - An issue or write in flight is discarded.
  - First capture happens on the first rising edge after rst_n rises.
- Storage updates, each rising clk:
  - R[PC_REG] <= pc_value.
  - If wr=1 and r_dest is neither 0 nor PC_REG, R[r_dest] <= wb_data.
  - R[0] is never written.
  - Writes to 0 or PC_REG are dropped silently and do not clear any pending bit.
- Reads (combinational, zero latency):
  - idx_z = is_store ? rd : rt.
  - Index 0 reads 0.
  - Index PC_REG reads the stored R[PC_REG], i.e. pc_value from the previous edge, never the live pc_value.
  - With BYPASS=1, if wr=1 and r_dest equals the read index and that index is a writable register, the bus returns wb_data. Otherwise it returns R[idx].
  - Each of the three ports resolves this independently; the same index on several ports returns identical data.
- Scoreboard, one pending bit per index, updated on the rising edge:
  - Set when iss_valid=1 and iss_dest is writable.
  - Cleared when wr=1 and r_dest equals the index.
  - Set and clear on the same index in the same cycle: the bit stays set, because the new producer wins.
  - Issuing to an already-pending index leaves it set; there is no per-register count and WAW ordering is owned by the pipeline.
  - Index 0 and PC_REG are never pending.
- busy_x (combinational) = pending[idx_x] AND NOT (BYPASS AND wr AND r_dest==idx_x).
  - When BYPASS=0, a register being written this cycle still reads busy until the next edge.
- pend_cnt: registered population count of the pending bits, updated on the same edge as the bits. Maximum value NREGS-2.
- No X on any output after reset, for any input combination.

Test Plan:
- Reset clear: write R5=0xDEADBEEF, then pulse rst_n low mid-cycle -> bus_y (rs=5) is 0 immediately with no clock edge, pend_cnt=0.
- Hardwired registers:
  - wr=1, r_dest=0, wb_data=0x1234 -> bus_y for rs=0 is 0.
  - wr=1, r_dest=30, wb_data=0x55 with pc_value=0x100 -> after the edge bus_p for rp=30 is 0x100.
  - pc_value changes to 0x104 -> bus_p stays 0x100 until the next edge.
- Store mux and bypass (BYPASS=1): R7=0x11, R9=0x22; is_store=1, rd=9, rt=7 -> bus_z=0x22. Same cycle wr=1, r_dest=9, wb_data=0x33 -> bus_z=0x33 before the edge.
- Bypass disabled (BYPASS=0): repeat the previous case -> bus_z=0x22 until the edge, then 0x33.
- Scoreboard basic:
  - iss_valid=1, iss_dest=12 -> the next cycle rs=12 gives busy_y=1, pend_cnt=1.
  - wr=1, r_dest=12 -> busy_y=0 that cycle with BYPASS=1, pend_cnt=0 after the edge.
- Simultaneous set and clear: R12 pending; same cycle iss_valid=1, iss_dest=12 and wr=1, r_dest=12 -> after the edge busy_y=1, pend_cnt=1, R12=wb_data. Issuing to 0 or 30 -> pend_cnt unchanged.
